wavetable_sample_reader: RTL and testbench
==========================================

// Module: wavetable_sample_reader
// PURPOSE
//  Avalon-MM read master that fetches wavetable samples from a 16-bit single-port on-chip sample ROM/RAM.
//  Once per audio sample tick it advances a fractional phase accumulator and reads the addressed word(s).
//  It presents one signed sample per tick on a valid/ready stream to the voice mixer.
//  It sits between the wavetable memory slave port and the per-voice mixer.
// PARAMETERS
//  ADDR_W       13    memory word-address width
//  DATA_W       16    sample width, two's complement
//  TABLE_WORDS  8094  table length; integer phase wraps modulo this value
//  PHASE_W      32    phase/increment width; FRAC_W = PHASE_W-ADDR_W (19) fractional bits
// PORTS
//  clk             in   1        system clock
//  reset           in   1        synchronous, active-high reset
//  enable          in   1        1 = accept ticks; 0 = ignore ticks and hold phase
//  phase_reset     in   1        note-on: force phase to 0 and clear overrun
//  tick            in   1        one-cycle sample-rate strobe
//  phase_inc       in   PHASE_W  {int[ADDR_W-1:0],frac[FRAC_W-1:0]}; int < TABLE_WORDS is required
//  avm_address     out  ADDR_W   word address
//  avm_chipselect  out  1        equals avm_read
//  avm_read        out  1        read strobe; memory has fixed read latency 1 and no waitrequest
//  avm_byteenable  out  2        constant 2'b11
//  avm_readdata    in   DATA_W   data valid 1 cycle after avm_read
//  sample_out      out  DATA_W   signed sample
//  sample_valid    out  1        held high until sample_ready
//  sample_ready    in   1        consumer accept
//  busy            out  1        state != IDLE
//  overrun         out  1        sticky: a tick was dropped
// BEHAVIOUR
//  Reset: state IDLE, phase 0, and every output 0 except avm_byteenable.
//   Reset mid-operation aborts the fetch; avm_read is low on the next cycle and no sample is produced.
//  FSM: IDLE -> RD0 -> [RD1] -> CAP -> OUT -> IDLE.
//   RD1 exists only with interpolation.
//   OUT returns to IDLE on sample_valid & sample_ready, in the same cycle.
//  IDLE with tick & enable: latch idx = phase.int and frac, then phase <= phase + phase_inc.
//   Integer part: int + inc.int + frac carry; subtract TABLE_WORDS if >= TABLE_WORDS.
//  RD0: avm_read=1, avm_address=idx.
//  CAP: register avm_readdata into sample_out (or the interpolated value).
//  OUT: sample_valid=1.
//   Without interpolation, valid asserts 3 cycles after the tick cycle.
//  tick while busy, or while enable=0: tick dropped, phase not advanced.
//   overrun is set only when busy. This includes OUT stalled on sample_ready.
//  phase_reset: phase <= 0 and overrun <= 0 in any state; it does not abort an in-flight fetch.
//   phase_reset together with tick in IDLE: fetch uses idx 0, then phase <= phase_inc.
//  enable=0 does not abort an in-flight fetch.
//  avm_read is never asserted in two consecutive cycles without interpolation.
// CONFIGURATION
//  WAVETABLE_LINEAR_INTERP_EN defined:
//   RD1 reads idx1 = (idx==TABLE_WORDS-1) ? 0 : idx+1. This is back-to-back with RD0.
//   s0 is captured in RD1, and s1 in CAP.
//   sample_out = s0 + (((s1-s0) * frac[FRAC_W-1:FRAC_W-16]) >>> 16).
//    The difference is 17-bit signed; the product is 33-bit signed, arithmetic shift.
//    The result always lies between s0 and s1, with no saturation.
//   Valid asserts 4 cycles after the tick cycle.
//  Undefined: single read per tick, frac ignored, sample_out = mem[idx].
// STRUCTURE
//  Package wavetable_pkg:
//   state enum {IDLE,RD0,RD1,CAP,OUT}
//   ADDR_W/DATA_W/PHASE_W defaults and FRAC_W localparam
//   function lerp16(s0,s1,f16)
//  Sub-module wt_phase_acc: phase register, modulo-TABLE_WORDS wrap, phase_reset, advance strobe.
//  Top level: FSM, Avalon master signals, output stream register.
// TESTING
//  Test 1: phase 0, inc int=1 frac=0, 4 ticks with ready=1.
//   Expect addresses 0,1,2,3 and sample_out = mem[0..3].
//   Expect valid 3 cycles after each tick (4 with interpolation).
//  Test 2: wrap. Phase int=8093, inc=1, two ticks.
//   Expect addresses 8093 then 0.
//   With interpolation, the RD1 addresses are 0 then 1.
//  Test 3 (interpolation): mem[5]=1000, mem[6]=2000, phase=5.5.
//   Expect 1500.
//   With mem[5]=100, mem[6]=-100 and frac .25, expect 50.
//  Test 4: hold sample_ready=0, tick again.
//   Expect overrun=1, sample_out unchanged, phase not advanced.
//   Then ready=1 returns to IDLE; phase_reset clears overrun.
//  Test 5: reset asserted in RD0.
//   Expect next cycle avm_read=0, sample_valid=0, phase=0, and no later sample.
//  Test 6: phase_reset and tick in the same IDLE cycle with inc=3.
//   Expect address 0, then phase int=3.

Source files
------------

// File: rtl/wavetable_pkg.sv
// Shared types, default widths and the interpolation helper for the
// wavetable sample reader.
package wavetable_pkg;

    localparam int ADDR_W_DEF      = 13;
    localparam int DATA_W_DEF      = 16;
    localparam int PHASE_W_DEF     = 32;
    localparam int TABLE_WORDS_DEF = 8094;
    localparam int FRAC_W_DEF      = PHASE_W_DEF - ADDR_W_DEF;

    typedef enum logic [2:0] {
        IDLE,
        RD0,
        RD1,
        CAP,
        OUT
    } state_t;

    // s0 + ((s1 - s0) * f16) >>> 16; the result always lies between s0 and s1,
    // so only the low 16 bits of the sum are kept.
    function automatic logic [15:0] lerp16(input logic [15:0] s0,
                                           input logic [15:0] s1,
                                           input logic [15:0] f16);
        logic signed [16:0] diff;
        logic signed [32:0] prod;
        logic signed [32:0] step;
        diff = $signed({s1[15], s1}) - $signed({s0[15], s0});
        prod = $signed({{16{diff[16]}}, diff}) * $signed({17'b0, f16});
        step = prod >>> 16;
        return s0 + step[15:0];
    endfunction

endpackage

// File: rtl/wt_phase_acc.sv
// Fractional phase accumulator: integer part wraps modulo TABLE_WORDS,
// phase_reset forces zero, advance adds phase_inc (from zero when both
// phase_reset and advance are high in the same cycle).
module wt_phase_acc
    import wavetable_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int PHASE_W     = PHASE_W_DEF,
    parameter int TABLE_WORDS = TABLE_WORDS_DEF,
    parameter int FRAC_W      = PHASE_W - ADDR_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               phase_reset,
    input  logic               advance,
    input  logic [PHASE_W-1:0] phase_inc,
    output logic [ADDR_W-1:0]  phase_int,
    output logic [FRAC_W-1:0]  phase_frac
);

    localparam logic [ADDR_W:0] TW = TABLE_WORDS[ADDR_W:0];

    logic [ADDR_W-1:0] int_q, int_d;
    logic [FRAC_W-1:0] frac_q, frac_d;
    logic [ADDR_W-1:0] base_int;
    logic [FRAC_W-1:0] base_frac;
    logic [FRAC_W:0]   frac_sum;
    logic [ADDR_W:0]   int_sum;
    logic [ADDR_W:0]   int_wrap;

    // Next phase: add increment with fractional carry, single conditional wrap
    // (int and inc.int are both below TABLE_WORDS, so one subtract suffices).
    always_comb begin
        base_int  = phase_reset ? '0 : int_q;
        base_frac = phase_reset ? '0 : frac_q;
        frac_sum  = {1'b0, base_frac} + {1'b0, phase_inc[FRAC_W-1:0]};
        int_sum   = {1'b0, base_int} + {1'b0, phase_inc[PHASE_W-1:FRAC_W]}
                  + {{ADDR_W{1'b0}}, frac_sum[FRAC_W]};
        int_wrap  = (int_sum >= TW) ? (int_sum - TW) : int_sum;
        int_d     = int_q;
        frac_d    = frac_q;
        if (advance) begin
            int_d  = int_wrap[ADDR_W-1:0];
            frac_d = frac_sum[FRAC_W-1:0];
        end else if (phase_reset) begin
            int_d  = '0;
            frac_d = '0;
        end
    end

    // Phase register
    always_ff @(posedge clk) begin
        if (reset) begin
            int_q  <= '0;
            frac_q <= '0;
        end else begin
            int_q  <= int_d;
            frac_q <= frac_d;
        end
    end

    assign phase_int  = int_q;
    assign phase_frac = frac_q;

endmodule

// File: rtl/wavetable_sample_reader.sv
// Wavetable sample reader: per-tick Avalon-MM read of a 16-bit sample table
// (fixed read latency 1) and a valid/ready output to the voice mixer.
// Build option WAVETABLE_LINEAR_INTERP_EN: fetch idx and idx+1 back to back
// and linearly interpolate with the top 16 fractional phase bits.
module wavetable_sample_reader
    import wavetable_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int TABLE_WORDS = TABLE_WORDS_DEF,
    parameter int PHASE_W     = PHASE_W_DEF
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic               phase_reset,
    input  logic               tick,
    input  logic [PHASE_W-1:0] phase_inc,
    output logic [ADDR_W-1:0]  avm_address,
    output logic               avm_chipselect,
    output logic               avm_read,
    output logic [1:0]         avm_byteenable,
    input  logic [DATA_W-1:0]  avm_readdata,
    output logic [DATA_W-1:0]  sample_out,
    output logic               sample_valid,
    input  logic               sample_ready,
    output logic               busy,
    output logic               overrun
);

    localparam int FRAC_W = PHASE_W - ADDR_W;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [DATA_W-1:0] sample_q, sample_d;
    logic              overrun_q, overrun_d;
    logic              advance;
    logic [ADDR_W-1:0] phase_int;
    logic [FRAC_W-1:0] phase_frac;

`ifdef WAVETABLE_LINEAR_INTERP_EN
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(TABLE_WORDS - 1);
    logic [DATA_W-1:0] s0_q, s0_d;
    logic [15:0]       frac16_q, frac16_d;
    logic [ADDR_W-1:0] idx1;
    assign idx1 = (idx_q == LAST_IDX) ? '0 : idx_q + ADDR_W'(1);
`else
    logic unused_frac;
    assign unused_frac = ^phase_frac;
`endif

    wt_phase_acc #(
        .ADDR_W      (ADDR_W),
        .PHASE_W     (PHASE_W),
        .TABLE_WORDS (TABLE_WORDS),
        .FRAC_W      (FRAC_W)
    ) u_phase_acc (
        .clk         (clk),
        .reset       (reset),
        .phase_reset (phase_reset),
        .advance     (advance),
        .phase_inc   (phase_inc),
        .phase_int   (phase_int),
        .phase_frac  (phase_frac)
    );

    // FSM next state, fetch index latch, sample capture and sticky overrun
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        sample_d  = sample_q;
        overrun_d = overrun_q;
        advance   = 1'b0;
`ifdef WAVETABLE_LINEAR_INTERP_EN
        s0_d      = s0_q;
        frac16_d  = frac16_q;
`endif
        // Any tick that arrives while a fetch is in flight (incl. a stalled OUT)
        // is lost; phase_reset takes priority and clears the flag.
        if (tick && (state_q != IDLE)) overrun_d = 1'b1;
        if (phase_reset)               overrun_d = 1'b0;

        case (state_q)
            IDLE: begin
                if (tick && enable) begin
                    advance = 1'b1;
                    idx_d   = phase_reset ? '0 : phase_int;
`ifdef WAVETABLE_LINEAR_INTERP_EN
                    frac16_d = phase_reset ? '0 : phase_frac[FRAC_W-1 -: 16];
`endif
                    state_d = RD0;
                end
            end
            RD0: begin
`ifdef WAVETABLE_LINEAR_INTERP_EN
                state_d = RD1;
`else
                state_d = CAP;
`endif
            end
`ifdef WAVETABLE_LINEAR_INTERP_EN
            RD1: begin
                s0_d    = avm_readdata;
                state_d = CAP;
            end
`endif
            CAP: begin
`ifdef WAVETABLE_LINEAR_INTERP_EN
                sample_d = lerp16(s0_q, avm_readdata, frac16_q);
`else
                sample_d = avm_readdata;
`endif
                state_d = OUT;
            end
            OUT: begin
                if (sample_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any fetch in progress
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            sample_q  <= '0;
            overrun_q <= 1'b0;
`ifdef WAVETABLE_LINEAR_INTERP_EN
            s0_q      <= '0;
            frac16_q  <= '0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            sample_q  <= sample_d;
            overrun_q <= overrun_d;
`ifdef WAVETABLE_LINEAR_INTERP_EN
            s0_q      <= s0_d;
            frac16_q  <= frac16_d;
`endif
        end
    end

    assign avm_read       = (state_q == RD0) || (state_q == RD1);
    assign avm_chipselect = avm_read;
    assign avm_byteenable = 2'b11;
`ifdef WAVETABLE_LINEAR_INTERP_EN
    assign avm_address    = (state_q == RD1) ? idx1 : idx_q;
`else
    assign avm_address    = idx_q;
`endif
    assign sample_out     = sample_q;
    assign sample_valid   = (state_q == OUT);
    assign busy           = (state_q != IDLE);
    assign overrun        = overrun_q;

endmodule

// File: tb/tb_wavetable_sample_reader.sv
// Self-checking bench for wavetable_sample_reader: table of tick vectors,
// a scoreboard of expected read addresses and samples, and hand-written
// sequences for overrun, reset-abort and interpolation corners.
module tb_wavetable_sample_reader;

    localparam int TW = 8094;
`ifdef WAVETABLE_LINEAR_INTERP_EN
    localparam bit INTERP = 1'b1;
`else
    localparam bit INTERP = 1'b0;
`endif
    localparam int LAT = INTERP ? 4 : 3;
    localparam logic [31:0] ONE = 32'h0008_0000;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b1;
    logic        phase_reset = 1'b0;
    logic        tick = 1'b0;
    logic [31:0] phase_inc = '0;
    logic [12:0] avm_address;
    logic        avm_chipselect;
    logic        avm_read;
    logic [1:0]  avm_byteenable;
    logic [15:0] avm_readdata = '0;
    logic [15:0] sample_out;
    logic        sample_valid;
    logic        sample_ready = 1'b1;
    logic        busy;
    logic        overrun;

    wavetable_sample_reader dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .phase_reset    (phase_reset),
        .tick           (tick),
        .phase_inc      (phase_inc),
        .avm_address    (avm_address),
        .avm_chipselect (avm_chipselect),
        .avm_read       (avm_read),
        .avm_byteenable (avm_byteenable),
        .avm_readdata   (avm_readdata),
        .sample_out     (sample_out),
        .sample_valid   (sample_valid),
        .sample_ready   (sample_ready),
        .busy           (busy),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    logic [15:0] mem [0:TW-1];
    always @(posedge clk) if (avm_read) avm_readdata <= mem[avm_address];

    int n_chk = 0;
    int n_fail = 0;
    int addr_q[$];
    logic [15:0] samp_q[$];
    int unsigned ph_int = 0, ph_frac = 0;
    logic prev_rd = 1'b0;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] lerp_m(input logic [15:0] a, input logic [15:0] b,
                                           input int unsigned f);
        longint s0, s1, p;
        s0 = longint'($signed(a));
        s1 = longint'($signed(b));
        p  = (s1 - s0) * longint'(f);
        return 16'(s0 + (p >>> 16));
    endfunction

    // Scoreboard: read addresses and accepted samples in order
    always @(negedge clk) begin
        if (!reset) begin
            if (avm_read) begin
                chk("chipselect", 32'(avm_chipselect), 1);
                if (!INTERP) chk("read_b2b", 32'(prev_rd), 0);
                if (addr_q.size() == 0) chk("unexpected_read", 32'(avm_address), 32'hffff_ffff);
                else chk("address", 32'(avm_address), addr_q.pop_front());
            end
            if (sample_valid && sample_ready) begin
                if (samp_q.size() == 0) chk("unexpected_sample", 32'(sample_out), 32'hffff_ffff);
                else chk("sample", 32'(sample_out), 32'(samp_q.pop_front()));
            end
        end
        prev_rd <= avm_read;
    end

    task automatic cyc();
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(); cyc();
        addr_q.delete();
        samp_q.delete();
        ph_int = 0;
        ph_frac = 0;
        reset = 1'b0;
    endtask

    // One accepted tick; ea >= 0 gives the expected fetch index literally,
    // otherwise the bench phase model supplies it.
    task automatic tick_once(input logic [31:0] inc, input logic pr, input int ea,
                             input logic has_lit, input logic [15:0] lit);
        int n;
        int unsigned idx, idx1, fr, fs, ni;
        idx  = pr ? 0 : ph_int;
        fr   = pr ? 0 : ph_frac;
        if (ea >= 0) idx = ea;
        idx1 = (idx == TW - 1) ? 0 : idx + 1;
        addr_q.push_back(idx);
        if (INTERP) begin
            addr_q.push_back(idx1);
            samp_q.push_back(lerp_m(mem[idx], mem[idx1], fr >> 3));
        end else begin
            samp_q.push_back(mem[idx]);
        end
        fs = fr + inc[18:0];
        ni = idx + inc[31:19] + (fs >> 19);
        if (ni >= TW) ni -= TW;
        ph_int  = ni;
        ph_frac = fs & 32'h7ffff;
        phase_inc = inc; phase_reset = pr; tick = 1'b1;
        cyc();
        tick = 1'b0; phase_reset = 1'b0;
        n = 1;
        while (!sample_valid && n < 20) begin cyc(); n++; end
        chk("valid_latency", n, LAT);
        if (has_lit) chk("sample_literal", 32'(sample_out), 32'(lit));
        if (sample_ready) cyc();
    endtask

    typedef struct {
        logic        rst;
        logic [31:0] inc;
        logic        pr;
        int          ea;
        logic        has_lit;
        logic [15:0] lit;
    } vec_t;

    vec_t tbl[12];

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < TW; i++) mem[i] = 16'((i * 211 + 13) ^ 16'h9c31);
        mem[5] = 16'd1000;
        mem[6] = 16'd2000;

        //        rst   inc                       pr    ea    lit?  lit
        tbl[0]  = '{1'b1, ONE,                    1'b0, 0,    1'b0, 16'd0};
        tbl[1]  = '{1'b0, ONE,                    1'b0, 1,    1'b0, 16'd0};
        tbl[2]  = '{1'b0, ONE,                    1'b0, 2,    1'b0, 16'd0};
        tbl[3]  = '{1'b0, ONE,                    1'b0, 3,    1'b0, 16'd0};
        tbl[4]  = '{1'b1, 32'(8093) << 19,        1'b0, 0,    1'b0, 16'd0};
        tbl[5]  = '{1'b0, ONE,                    1'b0, 8093, 1'b0, 16'd0};
        tbl[6]  = '{1'b0, ONE,                    1'b0, 0,    1'b0, 16'd0};
        tbl[7]  = '{1'b1, (32'd5 << 19) | (32'd1 << 18), 1'b0, 0, 1'b0, 16'd0};
        tbl[8]  = '{1'b0, ONE,                    1'b0, 5,    1'b1, INTERP ? 16'd1500 : 16'd1000};
        tbl[9]  = '{1'b1, 32'd2 << 19,            1'b0, 0,    1'b0, 16'd0};
        tbl[10] = '{1'b0, 32'd3 << 19,            1'b1, 0,    1'b0, 16'd0};
        tbl[11] = '{1'b0, ONE,                    1'b0, 3,    1'b0, 16'd0};

        // Reset state
        cyc(); cyc();
        chk("rst_read", 32'(avm_read), 0);
        chk("rst_cs", 32'(avm_chipselect), 0);
        chk("rst_addr", 32'(avm_address), 0);
        chk("rst_be", 32'(avm_byteenable), 3);
        chk("rst_sample", 32'(sample_out), 0);
        chk("rst_valid", 32'(sample_valid), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_overrun", 32'(overrun), 0);
        reset = 1'b0;
        cyc();

        // Sequential ticks, wrap, half-frac interpolation, phase_reset with tick
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].rst) do_reset();
            tick_once(tbl[i].inc, tbl[i].pr, tbl[i].ea, tbl[i].has_lit, tbl[i].lit);
        end

        // Negative slope, quarter frac
        do_reset();
        mem[5] = 16'd100;
        mem[6] = 16'hff9c;
        tick_once((32'd5 << 19) | (32'd1 << 17), 1'b0, 0, 1'b0, 16'd0);
        tick_once(ONE, 1'b0, 5, 1'b1, INTERP ? 16'd50 : 16'd100);

        // Overrun while OUT is stalled
        do_reset();
        sample_ready = 1'b0;
        tick_once(ONE, 1'b0, 0, 1'b1, mem[0]);
        phase_inc = ONE; tick = 1'b1;
        cyc();
        tick = 1'b0;
        chk("ovr_set", 32'(overrun), 1);
        chk("ovr_valid_held", 32'(sample_valid), 1);
        chk("ovr_sample_held", 32'(sample_out), 32'(mem[0]));
        cyc(); cyc();
        chk("ovr_sticky", 32'(overrun), 1);
        sample_ready = 1'b1;
        cyc();
        chk("ovr_idle", 32'(busy), 0);
        chk("ovr_sticky_idle", 32'(overrun), 1);
        tick_once(ONE, 1'b0, 1, 1'b0, 16'd0);
        phase_reset = 1'b1;
        cyc();
        phase_reset = 1'b0;
        ph_int = 0; ph_frac = 0;
        chk("ovr_cleared", 32'(overrun), 0);
        // enable low: tick ignored, no overrun
        enable = 1'b0; tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
        chk("dis_busy", 32'(busy), 0);
        chk("dis_overrun", 32'(overrun), 0);
        enable = 1'b1;
        tick_once(ONE, 1'b0, 0, 1'b0, 16'd0);

        // Reset during RD0 aborts the fetch
        do_reset();
        tick_once(ONE, 1'b0, 0, 1'b0, 16'd0);
        addr_q.push_back(1);
        phase_inc = 32'd7 << 19; tick = 1'b1;
        cyc();
        tick = 1'b0;
        chk("abort_in_rd0", 32'(avm_read), 1);
        reset = 1'b1;
        cyc();
        chk("abort_read", 32'(avm_read), 0);
        chk("abort_valid", 32'(sample_valid), 0);
        chk("abort_busy", 32'(busy), 0);
        reset = 1'b0;
        addr_q.delete(); samp_q.delete();
        ph_int = 0; ph_frac = 0;
        begin
            int seen = 0;
            repeat (8) begin cyc(); if (sample_valid) seen++; end
            chk("abort_no_sample", seen, 0);
        end
        tick_once(ONE, 1'b0, 0, 1'b0, 16'd0);

        repeat (3) cyc();
        chk("sb_addr_empty", addr_q.size(), 0);
        chk("sb_samp_empty", samp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
